// File: rtl/guess_evaluator.sv
// Registered guess evaluator: latches a secret, classifies each accepted guess
// as exact/close/wrong with a higher/lower hint, counts attempts and locks out.
module guess_evaluator #(
    parameter int WIDTH     = 4,
    parameter int THRESH    = 3,
    parameter int MAX_TRIES = 5
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               load,
    input  logic [WIDTH-1:0]                   secret,
    input  logic                               guess_valid,
    input  logic [WIDTH-1:0]                   guess,
    output logic                               guess_ready,
    output logic                               result_valid,
    output logic                               igual,
    output logic                               perto,
    output logic                               errada,
    output logic                               maior,
    output logic [$clog2(MAX_TRIES+1)-1:0]     tries,
    output logic                               venceu,
    output logic                               bloqueado
);

    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam logic [TW-1:0]    MAX_T    = TW'(MAX_TRIES);
    localparam logic [WIDTH-1:0] THRESH_W = WIDTH'(THRESH);

    typedef enum logic [1:0] {IDLE, ARMED, WON, LOCKED} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] secret_reg, secret_next;
    logic [TW-1:0]    tries_reg, tries_next, tries_inc;
    logic             igual_reg, igual_next;
    logic             perto_reg, perto_next;
    logic             errada_reg, errada_next;
    logic             maior_reg, maior_next;
    logic             result_valid_reg, result_valid_next;
    logic             venceu_reg, bloqueado_reg;

    logic [WIDTH:0]   diff, diff_neg;
    logic [WIDTH-1:0] mag;
    logic             accept, is_equal, is_close;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            secret_reg       <= '0;
            tries_reg        <= '0;
            igual_reg        <= 1'b0;
            perto_reg        <= 1'b0;
            errada_reg       <= 1'b0;
            maior_reg        <= 1'b0;
            result_valid_reg <= 1'b0;
            venceu_reg       <= 1'b0;
            bloqueado_reg    <= 1'b0;
        end else begin
            state_reg        <= state_next;
            secret_reg       <= secret_next;
            tries_reg        <= tries_next;
            igual_reg        <= igual_next;
            perto_reg        <= perto_next;
            errada_reg       <= errada_next;
            maior_reg        <= maior_next;
            result_valid_reg <= result_valid_next;
            venceu_reg       <= (state_next == WON);
            bloqueado_reg    <= (state_next == LOCKED);
        end
    end

    always_comb begin
        // One extra bit keeps the signed difference exact for any pair of operands.
        diff     = {1'b0, guess} - {1'b0, secret_reg};
        diff_neg = ~diff + 1'b1;
        mag      = diff[WIDTH] ? diff_neg[WIDTH-1:0] : diff[WIDTH-1:0];
        is_equal = (diff == '0);
        is_close = (mag != '0) && (mag <= THRESH_W);

        guess_ready = (state_reg == ARMED) && !load;
        accept      = guess_valid && guess_ready;
        tries_inc   = (tries_reg == MAX_T) ? tries_reg : tries_reg + TW'(1);

        state_next        = state_reg;
        secret_next       = secret_reg;
        tries_next        = tries_reg;
        igual_next        = igual_reg;
        perto_next        = perto_reg;
        errada_next       = errada_reg;
        maior_next        = maior_reg;
        result_valid_next = 1'b0;

        if (load) begin
            state_next  = ARMED;
            secret_next = secret;
            tries_next  = '0;
            igual_next  = 1'b0;
            perto_next  = 1'b0;
            errada_next = 1'b0;
            maior_next  = 1'b0;
        end else if (accept) begin
            igual_next        = is_equal;
            perto_next        = is_close;
            errada_next       = !is_equal && !is_close;
            maior_next        = !diff[WIDTH] && !is_equal;
            tries_next        = tries_inc;
            result_valid_next = 1'b1;
            if (is_equal) begin
                state_next = WON;
            end else if (tries_inc == MAX_T) begin
                state_next = LOCKED;
            end
        end
    end

    assign result_valid = result_valid_reg;
    assign igual        = igual_reg;
    assign perto        = perto_reg;
    assign errada       = errada_reg;
    assign maior        = maior_reg;
    assign tries        = tries_reg;
    assign venceu       = venceu_reg;
    assign bloqueado    = bloqueado_reg;

endmodule

// File: tb/tb_guess_evaluator.sv
// Bench for guess_evaluator: two parameter sets, directed plus random stimulus,
// scoreboard of result packets popped by per-instance monitors.
module tb_guess_evaluator;

    localparam int W0 = 4, T0 = 3, M0 = 5;
    localparam int W1 = 6, T1 = 5, M1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n_s [2];
    logic       load_s  [2];
    logic       gv_s    [2];
    logic [3:0] sec0, g0;
    logic [5:0] sec1, g1;

    logic       gr0, rv0, ig0, pe0, er0, ma0, ve0, bl0;
    logic [2:0] tr0;
    logic       gr1, rv1, ig1, pe1, er1, ma1, ve1, bl1;
    logic [1:0] tr1;

    // Observation word: {tries[7:0], bloqueado, venceu, maior, errada, perto, igual, result_valid, guess_ready}
    logic [15:0] obs [2];
    assign obs[0] = {5'b0, tr0, bl0, ve0, ma0, er0, pe0, ig0, rv0, gr0};
    assign obs[1] = {6'b0, tr1, bl1, ve1, ma1, er1, pe1, ig1, rv1, gr1};

    guess_evaluator #(.WIDTH(W0), .THRESH(T0), .MAX_TRIES(M0)) dut0 (
        .clk(clk), .rst_n(rst_n_s[0]), .load(load_s[0]), .secret(sec0),
        .guess_valid(gv_s[0]), .guess(g0), .guess_ready(gr0), .result_valid(rv0),
        .igual(ig0), .perto(pe0), .errada(er0), .maior(ma0), .tries(tr0),
        .venceu(ve0), .bloqueado(bl0));

    guess_evaluator #(.WIDTH(W1), .THRESH(T1), .MAX_TRIES(M1)) dut1 (
        .clk(clk), .rst_n(rst_n_s[1]), .load(load_s[1]), .secret(sec1),
        .guess_valid(gv_s[1]), .guess(g1), .guess_ready(gr1), .result_valid(rv1),
        .igual(ig1), .perto(pe1), .errada(er1), .maior(ma1), .tries(tr1),
        .venceu(ve1), .bloqueado(bl1));

    int checks = 0;
    int errors = 0;

    // Reference model state: 0 idle, 1 armed, 2 won, 3 locked
    int   m_st [2], m_sec [2], m_tr [2];
    logic m_ig [2], m_pe [2], m_er [2], m_ma [2], m_rv [2];

    logic [13:0] sb0 [$];
    logic [13:0] sb1 [$];

    function automatic int pw(int d); return (d == 0) ? W0 : W1; endfunction
    function automatic int pt(int d); return (d == 0) ? T0 : T1; endfunction
    function automatic int pm(int d); return (d == 0) ? M0 : M1; endfunction

    function automatic void check(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [15:0] model_obs(int d, logic gr);
        logic [7:0] t;
        t = 8'(m_tr[d]);
        return {t, (m_st[d] == 3), (m_st[d] == 2), m_ma[d], m_er[d], m_pe[d],
                m_ig[d], m_rv[d], gr};
    endfunction

    function automatic void model_reset(int d);
        m_st[d] = 0; m_sec[d] = 0; m_tr[d] = 0;
        m_ig[d] = 0; m_pe[d] = 0; m_er[d] = 0; m_ma[d] = 0; m_rv[d] = 0;
        if (d == 0) sb0.delete(); else sb1.delete();
    endfunction

    always @(negedge clk) begin
        if (rst_n_s[0] === 1'b1 && obs[0][1] === 1'b1) begin
            if (sb0.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb0_unexpected_result: got result_valid=1 expected no result (t=%0t)", $time);
            end else begin
                logic [13:0] e0;
                e0 = sb0.pop_front();
                check("sb0_result", {2'b0, obs[0][15:2]}, {2'b0, e0});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n_s[1] === 1'b1 && obs[1][1] === 1'b1) begin
            if (sb1.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb1_unexpected_result: got result_valid=1 expected no result (t=%0t)", $time);
            end else begin
                logic [13:0] e1;
                e1 = sb1.pop_front();
                check("sb1_result", {2'b0, obs[1][15:2]}, {2'b0, e1});
            end
        end
    end

    task automatic drive(int d, bit ld, int sec, bit gv, int g);
        load_s[d] = ld;
        gv_s[d]   = gv;
        if (d == 0) begin
            sec0 = sec[3:0]; g0 = g[3:0];
        end else begin
            sec1 = sec[5:0]; g1 = g[5:0];
        end
    endtask

    // One clock cycle of stimulus; entered and left at posedge+1.
    task automatic step(int d, bit ld, int sec, bit gv, int g);
        int mask, gm, sm, diff, mag;
        logic gr_exp;
        logic [15:0] e;
        mask = (1 << pw(d)) - 1;
        gm = g & mask;
        sm = sec & mask;
        drive(d, ld, sm, gv, gm);
        #1;
        gr_exp = (m_st[d] == 1) && !ld;
        check($sformatf("d%0d_guess_ready", d), {15'b0, obs[d][0]}, {15'b0, gr_exp});
        if (ld) begin
            m_st[d] = 1; m_sec[d] = sm; m_tr[d] = 0;
            m_ig[d] = 0; m_pe[d] = 0; m_er[d] = 0; m_ma[d] = 0; m_rv[d] = 0;
        end else if (gv && m_st[d] == 1) begin
            diff = gm - m_sec[d];
            mag  = (diff < 0) ? -diff : diff;
            m_ig[d] = (diff == 0);
            m_pe[d] = (mag >= 1) && (mag <= pt(d));
            m_er[d] = !m_ig[d] && !m_pe[d];
            m_ma[d] = (diff > 0);
            m_tr[d] = (m_tr[d] + 1 > pm(d)) ? pm(d) : m_tr[d] + 1;
            m_st[d] = m_ig[d] ? 2 : ((m_tr[d] == pm(d)) ? 3 : 1);
            m_rv[d] = 1;
            e = model_obs(d, 1'b0);
            if (d == 0) sb0.push_back(e[15:2]); else sb1.push_back(e[15:2]);
        end else begin
            m_rv[d] = 0;
        end
        @(posedge clk);
        #1;
        drive(d, 0, 0, 0, 0);
        e = model_obs(d, 1'b0);
        check($sformatf("d%0d_state", d), {1'b0, obs[d][15:1]}, {1'b0, e[15:1]});
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic rst_mid(int d);
        #2;
        rst_n_s[d] = 1'b0;
        #1;
        model_reset(d);
        check($sformatf("d%0d_async_reset", d), obs[d], 16'h0000);
        #2;
        rst_n_s[d] = 1'b1;
        @(posedge clk);
        #1;
        check($sformatf("d%0d_after_reset", d), obs[d], 16'h0000);
    endtask

    task automatic run_directed(int d);
        int mx;
        mx = (1 << pw(d)) - 1;
        step(d, 0, 0, 1, 5);                      // ignored in IDLE
        step(d, 1, 7, 0, 0); step(d, 0, 0, 1, 7); // win
        step(d, 0, 0, 1, 7);                      // ignored in WON
        step(d, 1, 7, 0, 0);
        step(d, 0, 0, 1, 10); step(d, 0, 0, 1, 4); step(d, 0, 0, 1, 11);
        step(d, 1, 0, 0, 0);  step(d, 0, 0, 1, mx);
        step(d, 1, mx, 0, 0); step(d, 0, 0, 1, mx - 3);
        step(d, 1, mx, 0, 0); step(d, 0, 0, 1, mx);
        step(d, 1, 0, 0, 0);  step(d, 0, 0, 1, 0);
        step(d, 1, 2, 0, 0);
        for (int i = 0; i < pm(d); i++) step(d, 0, 0, 1, 9);
        step(d, 0, 0, 1, 2);                      // ignored in LOCKED
        step(d, 1, 3, 1, 3); step(d, 0, 0, 1, 3); // load beats guess
        step(d, 1, 2, 0, 0); step(d, 0, 0, 1, 9); step(d, 0, 0, 1, 9);
        rst_mid(d);
        step(d, 0, 0, 1, 2);
        step(d, 1, 2, 0, 0); step(d, 0, 0, 1, 2);
    endtask

    task automatic run_random(int d);
        int r, g;
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                rst_mid(d);
            end else begin
                if ($urandom_range(0, 1) == 1)
                    g = m_sec[d] + int'($urandom_range(0, 2 * pt(d) + 2)) - pt(d) - 1;
                else
                    g = int'($urandom);
                step(d, r < 12, int'($urandom), $urandom_range(0, 3) != 0, g);
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n_s[d] = 1'b0;
            drive(d, 0, 0, 0, 0);
            model_reset(d);
        end
        @(posedge clk);
        #1;
        check("d0_reset", obs[0], 16'h0000);
        check("d1_reset", obs[1], 16'h0000);
        rst_n_s[0] = 1'b1;
        rst_n_s[1] = 1'b1;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            run_directed(d);
            run_random(d);
        end
        @(negedge clk);
        #1;
        check("sb0_drained", 16'(sb0.size()), 16'h0000);
        check("sb1_drained", 16'(sb1.size()), 16'h0000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
